// File: rtl/fpmac_vector_checker.sv
// fpmac_vector_checker
//   Synthesizable stimulus issuer and result checker for a BF16 x BF16 + FP32
//   multiply-accumulate unit. It takes a stream of (A, B, C, ideal) vectors,
//   drives A/B/C to the MAC through registers, samples the MAC result a fixed
//   number of edges later, and keeps pass/fail counts plus a capture of the
//   first failing vector.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, num_vectors              run request and run length (sampled on start)
//   vec_valid/vec_ready             vector stream handshake
//   vec_a, vec_b, vec_c, vec_ideal  operands and golden result
//   mac_a, mac_b, mac_c             registered operands to the MAC
//   mac_result                      MAC output
//   busy, done                      run status, one-cycle end-of-run pulse
//   pass_count, fail_count          per-run result counters
//   first_fail_*                    capture of the first mismatching vector
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting vectors, comparing results as they emerge
// DRAIN | all vectors issued, waiting for the delay line to empty
// DONE  | run finished; done pulses on the following cycle
module fpmac_vector_checker #(
    parameter int WIDTH       = 16,
    parameter int CWIDTH      = 32,
    parameter int MAC_LATENCY = 1,
    parameter int CNT_W       = 16,
    parameter bit NAN_EQUIV   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [WIDTH-1:0]  vec_a,
    input  logic [WIDTH-1:0]  vec_b,
    input  logic [CWIDTH-1:0] vec_c,
    input  logic [CWIDTH-1:0] vec_ideal,
    output logic [WIDTH-1:0]  mac_a,
    output logic [WIDTH-1:0]  mac_b,
    output logic [CWIDTH-1:0] mac_c,
    input  logic [CWIDTH-1:0] mac_result,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              first_fail_valid,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [CWIDTH-1:0] first_fail_result,
    output logic [CWIDTH-1:0] first_fail_ideal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  num_lat;
    logic [CNT_W-1:0]  issue_idx;

    // Delay line: stage MAC_LATENCY-1 is the one compared at each edge.
    logic [MAC_LATENCY-1:0] dl_valid;
    logic [CWIDTH-1:0]      dl_ideal [MAC_LATENCY];
    logic [CNT_W-1:0]       dl_idx   [MAC_LATENCY];

    logic              xfer;
    logic              last_xfer;
    logic              shifting;
    logic              cmp_en;
    logic              rest_empty;
    logic              match;
    logic [CWIDTH-1:0] out_ideal;

    function automatic logic is_nan(input logic [CWIDTH-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    assign vec_ready = (state == RUN);
    assign busy      = (state != IDLE);
    assign xfer      = vec_valid & vec_ready;
    assign last_xfer = xfer && (issue_idx == num_lat - CNT_W'(1));
    assign shifting  = (state == RUN) || (state == DRAIN);
    assign cmp_en    = shifting && dl_valid[MAC_LATENCY-1];
    assign out_ideal = dl_ideal[MAC_LATENCY-1];
    assign match     = (mac_result == out_ideal) ||
                       (NAN_EQUIV && is_nan(mac_result) && is_nan(out_ideal));

    // True when every stage except the outgoing one is empty, so after this
    // edge's compare nothing is left in flight.
    always_comb begin
        rest_empty = 1'b1;
        for (int i = 0; i < MAC_LATENCY - 1; i++) begin
            if (dl_valid[i]) begin
                rest_empty = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_xfer) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rest_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_a             <= '0;
            mac_b             <= '0;
            mac_c             <= '0;
            num_lat           <= '0;
            issue_idx         <= '0;
            done              <= 1'b0;
            pass_count        <= '0;
            fail_count        <= '0;
            first_fail_valid  <= 1'b0;
            first_fail_idx    <= '0;
            first_fail_result <= '0;
            first_fail_ideal  <= '0;
            dl_valid          <= '0;
            for (int i = 0; i < MAC_LATENCY; i++) begin
                dl_ideal[i] <= '0;
                dl_idx[i]   <= '0;
            end
        end else begin
            // done is registered so it follows the DONE state by one edge.
            done <= (state == DONE);

            if (state == IDLE && start) begin
                num_lat           <= num_vectors;
                issue_idx         <= '0;
                pass_count        <= '0;
                fail_count        <= '0;
                first_fail_valid  <= 1'b0;
                first_fail_idx    <= '0;
                first_fail_result <= '0;
                first_fail_ideal  <= '0;
            end

            if (xfer) begin
                mac_a     <= vec_a;
                mac_b     <= vec_b;
                mac_c     <= vec_c;
                issue_idx <= issue_idx + CNT_W'(1);
            end

            if (shifting) begin
                for (int i = MAC_LATENCY - 1; i > 0; i--) begin
                    dl_valid[i] <= dl_valid[i-1];
                    dl_ideal[i] <= dl_ideal[i-1];
                    dl_idx[i]   <= dl_idx[i-1];
                end
                dl_valid[0] <= xfer;
                dl_ideal[0] <= xfer ? vec_ideal : '0;
                dl_idx[0]   <= xfer ? issue_idx : '0;
            end else begin
                dl_valid <= '0;
            end

            if (cmp_en) begin
                if (match) begin
                    pass_count <= pass_count + CNT_W'(1);
                end else begin
                    fail_count <= fail_count + CNT_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_valid  <= 1'b1;
                        first_fail_idx    <= dl_idx[MAC_LATENCY-1];
                        first_fail_result <= mac_result;
                        first_fail_ideal  <= out_ideal;
                    end
                end
            end
        end
    end

endmodule
